bus_arbiter: RTL and testbench

Two-master arbiter for the shared 8-bit peripheral bus (BUS_ADDR, BUS_DATA, BUS_WE) used by the memory-mapped peripherals such as the LED and seven-segment blocks. Master 0 is the processor; master 1 is a secondary bus master, for example an LED pattern sequencer. The block grants the bus to one master at a time with round-robin fairness and a bounded hold time. It inserts a parked idle cycle between owners so peripherals never see a mixed address stream and BUS_DATA is never double-driven.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter.sv | 110 +++++++++++
 tb/tb_bus_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master peripheral bus: widths, park address
// and the arbiter state encoding.
package bus_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Must decode to no peripheral so an unowned bus is harmless.
    localparam logic [ADDR_W-1:0] PARK_ADDR_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter with bounded hold time and one parked
// IDLE cycle between owners.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned        MAX_HOLD  = 16,
    parameter logic [ADDR_W-1:0]  PARK_ADDR = PARK_ADDR_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              M0_REQ,
    input  logic              M1_REQ,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic              M0_WE,
    input  logic              M1_WE,
    input  logic [DATA_W-1:0] M0_DATA_OUT,
    input  logic [DATA_W-1:0] M1_DATA_OUT,
    output logic              M0_GNT,
    output logic              M1_GNT,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic              BUS_WE,
    inout  wire  [DATA_W-1:0] BUS_DATA,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              OWNER
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t        r_state;
    logic              r_owner;
    logic [CNT_W-1:0]  r_hold_cnt;

    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic [DATA_W-1:0] w_data;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_owner    <= 1'b1;   // M0 wins the first tie after reset
            r_hold_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // On a tie the master that did not own the bus last wins.
                    if (M0_REQ && (!M1_REQ || r_owner)) begin
                        r_state    <= GNT0;
                        r_owner    <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (M1_REQ) begin
                        r_state    <= GNT1;
                        r_owner    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                GNT0: begin
                    if (!M0_REQ || (M1_REQ && (r_hold_cnt == HOLD_LAST))) begin
                        r_state <= IDLE;
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                GNT1: begin
                    if (!M1_REQ || (M0_REQ && (r_hold_cnt == HOLD_LAST))) begin
                        r_state <= IDLE;
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bus mux is selected by the registered state only, never by REQ.
    always_comb begin
        w_addr = PARK_ADDR;
        w_we   = 1'b0;
        w_data = '0;
        unique case (r_state)
            GNT0: begin
                w_addr = M0_ADDR;
                w_we   = M0_WE;
                w_data = M0_DATA_OUT;
            end
            GNT1: begin
                w_addr = M1_ADDR;
                w_we   = M1_WE;
                w_data = M1_DATA_OUT;
            end
            default: begin
                w_addr = PARK_ADDR;
                w_we   = 1'b0;
                w_data = '0;
            end
        endcase
    end

    assign BUS_ADDR = w_addr;
    assign BUS_WE   = w_we;
    assign BUS_DATA = w_we ? w_data : {DATA_W{1'bz}};
    assign RD_DATA  = BUS_DATA;

    assign M0_GNT = (r_state == GNT0);
    assign M1_GNT = (r_state == GNT1);
    assign OWNER  = r_owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a cycle table for reset/round-robin/release,
// plus hand sequences for LED write, read across preemption, long hold and reset.
module tb_bus_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m1_req, m0_we, m1_we;
    logic [7:0] m0_addr, m1_addr, m0_data, m1_data;
    logic       m0_gnt, m1_gnt, bus_we, owner;
    logic [7:0] bus_addr, rd_data;
    wire  [7:0] bus_data;

    // Bench peripheral (LED register pair at C0/C1) and a 00 probe driver
    // used to detect whether the arbiter is driving the data bus.
    logic [15:0] led = 16'h0000;
    logic        per_en = 1'b0;
    logic [7:0]  per_val = 8'h00;
    logic        probe_en = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign bus_data = (per_en && !bus_we) ? per_val :
                      ((probe_en && !bus_we) ? 8'h00 : 8'hzz);

    always @(posedge clk) begin
        per_en <= 1'b0;
        if (bus_we && bus_addr == 8'hC0) led[7:0]  <= bus_data;
        if (bus_we && bus_addr == 8'hC1) led[15:8] <= bus_data;
        if (!bus_we && (bus_addr == 8'hC0 || bus_addr == 8'hC1)) begin
            per_en  <= 1'b1;
            per_val <= bus_addr[0] ? led[15:8] : led[7:0];
        end
    end

    bus_arbiter #(.MAX_HOLD(MAX_HOLD), .PARK_ADDR(8'hFF)) dut (
        .CLK(clk), .RESET(rst_n),
        .M0_REQ(m0_req), .M1_REQ(m1_req),
        .M0_ADDR(m0_addr), .M1_ADDR(m1_addr),
        .M0_WE(m0_we), .M1_WE(m1_we),
        .M0_DATA_OUT(m0_data), .M1_DATA_OUT(m1_data),
        .M0_GNT(m0_gnt), .M1_GNT(m1_gnt),
        .BUS_ADDR(bus_addr), .BUS_WE(bus_we), .BUS_DATA(bus_data),
        .RD_DATA(rd_data), .OWNER(owner)
    );

    // Grants must never overlap.
    always @(negedge clk) begin
        if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
            bad = bad + 1;
            $display("FAIL gnt_overlap actual=11 required=not both high");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n, req0, req1, we0, we1;
        logic       g0, g1;
        logic [7:0] addr;
        logic       we, own;
    } vec_t;

    vec_t vecs[21];
    logic got;

    initial begin
        //           rst req0 req1 we0 we1   g0 g1 addr    we own
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,8'hFF,1'b0,1'b1};
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,8'h10,1'b1,1'b0};
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = vecs[3];
        vecs[7]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,8'hFF,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,8'h20,1'b1,1'b1};
        vecs[9]  = vecs[8];
        vecs[10] = vecs[8];
        vecs[11] = vecs[8];
        vecs[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,8'hFF,1'b0,1'b1};
        vecs[13] = vecs[3];
        vecs[14] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,8'hFF,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,8'h20,1'b1,1'b1};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,8'hFF,1'b0,1'b1};
        vecs[17] = vecs[16];
        vecs[18] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,8'h10,1'b0,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,8'hFF,1'b0,1'b0};
        vecs[20] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,8'h20,1'b1,1'b1};

        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = 8'h10; m1_addr = 8'h20; m0_data = 8'h3C; m1_data = 8'hC3;
        m0_we = 1'b0; m1_we = 1'b0; probe_en = 1'b1;

        // Table: reset with both requesting, round-robin at MAX_HOLD=4, release paths.
        for (int i = 0; i < 21; i++) begin
            rst_n = vecs[i].rst_n; m0_req = vecs[i].req0; m1_req = vecs[i].req1;
            m0_we = vecs[i].we0;   m1_we = vecs[i].we1;
            tick();
            $display("vec %0d: gnt=%b%b addr=%h we=%b own=%b data=%h",
                     i, m0_gnt, m1_gnt, bus_addr, bus_we, owner, bus_data);
            chk($sformatf("v%0d_gnt0", i), {7'd0, m0_gnt}, {7'd0, vecs[i].g0});
            chk($sformatf("v%0d_gnt1", i), {7'd0, m1_gnt}, {7'd0, vecs[i].g1});
            chk($sformatf("v%0d_addr", i), bus_addr, vecs[i].addr);
            chk($sformatf("v%0d_we", i), {7'd0, bus_we}, {7'd0, vecs[i].we});
            chk($sformatf("v%0d_owner", i), {7'd0, owner}, {7'd0, vecs[i].own});
            // Undriven bus reads the probe's 00; a driven bus shows the owner's data.
            chk($sformatf("v%0d_data", i), bus_data,
                vecs[i].we ? (vecs[i].g0 ? 8'h3C : 8'hC3) : 8'h00);
        end

        // Single master write of A5 to LED high byte.
        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; tick(); rst_n = 1'b1;
        m1_addr = 8'hC1; m1_we = 1'b1; m1_data = 8'hA5; m1_req = 1'b1;
        chk("wr_gnt1_before_edge", {7'd0, m1_gnt}, 8'h00);
        tick();
        $display("led write: gnt1=%b addr=%h we=%b data=%h", m1_gnt, bus_addr, bus_we, bus_data);
        chk("wr_gnt1", {7'd0, m1_gnt}, 8'h01);
        chk("wr_addr", bus_addr, 8'hC1);
        chk("wr_we", {7'd0, bus_we}, 8'h01);
        chk("wr_data", bus_data, 8'hA5);
        m1_req = 1'b0; tick();
        $display("led write done: led=%h", led);
        chk("wr_led_hi", led[15:8], 8'hA5);
        chk("wr_release_addr", bus_addr, 8'hFF);

        // Read of C0 in M0's last granted cycle, returned during the IDLE after preemption.
        m0_addr = 8'hC0; m0_we = 1'b1; m0_data = 8'h5A; m0_req = 1'b1;
        tick();
        chk("rd_gnt0", {7'd0, m0_gnt}, 8'h01);
        tick();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h20;
        m0_we = 1'b0; m0_data = 8'hA5;
        tick(); tick();
        chk("rd_last_gnt0", {7'd0, m0_gnt}, 8'h01);
        chk("rd_last_addr", bus_addr, 8'hC0);
        tick();
        $display("preempt read: gnt=%b%b addr=%h rd=%h data=%h", m0_gnt, m1_gnt, bus_addr, rd_data, bus_data);
        chk("rd_idle_gnt0", {7'd0, m0_gnt}, 8'h00);
        chk("rd_idle_gnt1", {7'd0, m1_gnt}, 8'h00);
        chk("rd_idle_addr", bus_addr, 8'hFF);
        chk("rd_data", rd_data, 8'h5A);
        chk("rd_bus_data", bus_data, 8'h5A);
        tick();
        chk("rd_regrant_gnt1", {7'd0, m1_gnt}, 8'h01);
        chk("rd_regrant_owner", {7'd0, owner}, 8'h01);
        m1_req = 1'b0; m0_req = 1'b0; tick();

        // Lone long holder, then handover once M1 requests.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        m0_addr = 8'h10; m0_we = 1'b1; m0_data = 8'h3C; m0_req = 1'b1;
        tick();
        for (int c = 0; c < 50; c++) begin
            chk($sformatf("hold_c%0d", c), {7'd0, m0_gnt}, 8'h01);
            tick();
        end
        $display("lone hold: 50 cycles, gnt0=%b", m0_gnt);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h20; m1_data = 8'hC3;
        got = 1'b0;
        for (int c = 0; c < MAX_HOLD + 1; c++) begin
            tick();
            if (m1_gnt) begin
                got = 1'b1;
                break;
            end
        end
        $display("handover: gnt1=%b", m1_gnt);
        chk("handover_within_bound", {7'd0, got}, 8'h01);

        // Mid-tenure reset while M1 is writing.
        chk("mid_pre_we", {7'd0, bus_we}, 8'h01);
        rst_n = 1'b0; tick();
        $display("mid reset: gnt=%b%b addr=%h we=%b own=%b data=%h", m0_gnt, m1_gnt, bus_addr, bus_we, owner, bus_data);
        chk("mid_gnt1", {7'd0, m1_gnt}, 8'h00);
        chk("mid_we", {7'd0, bus_we}, 8'h00);
        chk("mid_addr", bus_addr, 8'hFF);
        chk("mid_data_z", bus_data, 8'h00);
        chk("mid_owner", {7'd0, owner}, 8'h01);

        // Reset during an M0 tenure must also restore OWNER=1, then M0 wins the tie.
        rst_n = 1'b1; m1_req = 1'b0; m0_req = 1'b1; tick();
        chk("m0rst_pre_owner", {7'd0, owner}, 8'h00);
        rst_n = 1'b0; tick();
        chk("m0rst_owner", {7'd0, owner}, 8'h01);
        chk("m0rst_gnt0", {7'd0, m0_gnt}, 8'h00);
        rst_n = 1'b1; m1_req = 1'b1; tick();
        $display("tie after reset: gnt=%b%b own=%b", m0_gnt, m1_gnt, owner);
        chk("tie_gnt0", {7'd0, m0_gnt}, 8'h01);
        chk("tie_gnt1", {7'd0, m1_gnt}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
